// File: rtl/sram_fpga_2rw.sv
// Behavioural true-dual-port synchronous SRAM with per-lane write masks.
// Used as the FPGA/simulation fallback when no ASIC macro is selected.
module sram_fpga_2rw #(
  parameter int  DEPTH      = 1024,
  parameter int  ADDR_WIDTH = 10,
  parameter int  DATA_WIDTH = 32,
  parameter int  MASK_UNIT  = 8,
  localparam int MASK_WIDTH = DATA_WIDTH / MASK_UNIT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rw0_enable,
  input  logic                  rw0_write,
  input  logic [ADDR_WIDTH-1:0] rw0_addr,
  input  logic [MASK_WIDTH-1:0] rw0_mask,
  input  logic [DATA_WIDTH-1:0] rw0_dataIn,
  output logic [DATA_WIDTH-1:0] rw0_dataOut,
  input  logic                  rw1_enable,
  input  logic                  rw1_write,
  input  logic [ADDR_WIDTH-1:0] rw1_addr,
  input  logic [MASK_WIDTH-1:0] rw1_mask,
  input  logic [DATA_WIDTH-1:0] rw1_dataIn,
  output logic [DATA_WIDTH-1:0] rw1_dataOut
);

  if (DATA_WIDTH % MASK_UNIT != 0) begin : g_bad_mask_unit
    $fatal(1, "sram_fpga_2rw: DATA_WIDTH must be a multiple of MASK_UNIT");
  end
  if ((64'(1) << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_addr_width
    $fatal(1, "sram_fpga_2rw: ADDR_WIDTH too small for DEPTH");
  end

  typedef logic [MASK_WIDTH-1:0][MASK_UNIT-1:0] word_t;

  // One extra bit so DEPTH == 2^ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  word_t mem [DEPTH];

`ifdef SRAM_INIT_ZERO
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end
`endif

  logic  rw0_in_range;
  logic  rw1_in_range;
  logic  rw0_wr;
  logic  rw1_wr;
  word_t rw0_din;
  word_t rw1_din;

  logic [DATA_WIDTH-1:0] rw0_dout_d, rw0_dout_q;
  logic [DATA_WIDTH-1:0] rw1_dout_d, rw1_dout_q;

  always_comb begin
    rw0_in_range = ({1'b0, rw0_addr} < DEPTH_W);
    rw1_in_range = ({1'b0, rw1_addr} < DEPTH_W);
    rw0_wr       = reset_n && rw0_enable && rw0_write && rw0_in_range;
    rw1_wr       = reset_n && rw1_enable && rw1_write && rw1_in_range;
    rw0_din      = word_t'(rw0_dataIn);
    rw1_din      = word_t'(rw1_dataIn);
  end

  // Reads sample the array before this edge's writes land, giving
  // read-before-write across ports; writes leave dataOut unchanged.
  always_comb begin
    rw0_dout_d = rw0_dout_q;
    rw1_dout_d = rw1_dout_q;
    if (rw0_enable && !rw0_write) begin
      rw0_dout_d = rw0_in_range ? DATA_WIDTH'(mem[rw0_addr]) : '0;
    end
    if (rw1_enable && !rw1_write) begin
      rw1_dout_d = rw1_in_range ? DATA_WIDTH'(mem[rw1_addr]) : '0;
    end
  end

  // Port 1 lane writes are issued last, so they win on a shared lane.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
      if (rw0_wr && rw0_mask[i]) mem[rw0_addr][i] <= rw0_din[i];
      if (rw1_wr && rw1_mask[i]) mem[rw1_addr][i] <= rw1_din[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rw0_dout_q <= '0;
      rw1_dout_q <= '0;
    end else begin
      rw0_dout_q <= rw0_dout_d;
      rw1_dout_q <= rw1_dout_d;
    end
  end

  assign rw0_dataOut = rw0_dout_q;
  assign rw1_dataOut = rw1_dout_q;

endmodule

// File: tb/tb_sram_fpga_2rw.sv
// Directed self-checking bench for sram_fpga_2rw (DEPTH=1000 to exercise the
// out-of-range address window).
module tb_sram_fpga_2rw;

  logic        clock;
  logic        reset_n;
  logic        rw0_enable, rw0_write;
  logic [9:0]  rw0_addr;
  logic [3:0]  rw0_mask;
  logic [31:0] rw0_dataIn, rw0_dataOut;
  logic        rw1_enable, rw1_write;
  logic [9:0]  rw1_addr;
  logic [3:0]  rw1_mask;
  logic [31:0] rw1_dataIn, rw1_dataOut;

  int checks = 0;
  int errors = 0;

  sram_fpga_2rw #(
    .DEPTH      (1000),
    .ADDR_WIDTH (10),
    .DATA_WIDTH (32),
    .MASK_UNIT  (8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rw0_enable  (rw0_enable),
    .rw0_write   (rw0_write),
    .rw0_addr    (rw0_addr),
    .rw0_mask    (rw0_mask),
    .rw0_dataIn  (rw0_dataIn),
    .rw0_dataOut (rw0_dataOut),
    .rw1_enable  (rw1_enable),
    .rw1_write   (rw1_write),
    .rw1_addr    (rw1_addr),
    .rw1_mask    (rw1_mask),
    .rw1_dataIn  (rw1_dataIn),
    .rw1_dataOut (rw1_dataOut)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic p0(input logic en, input logic we, input logic [9:0] a,
                    input logic [3:0] m, input logic [31:0] d);
    rw0_enable = en; rw0_write = we; rw0_addr = a; rw0_mask = m; rw0_dataIn = d;
  endtask

  task automatic p1(input logic en, input logic we, input logic [9:0] a,
                    input logic [3:0] m, input logic [31:0] d);
    rw1_enable = en; rw1_write = we; rw1_addr = a; rw1_mask = m; rw1_dataIn = d;
  endtask

  task automatic idle();
    p0(1'b0, 1'b0, '0, '0, '0);
    p1(1'b0, 1'b0, '0, '0, '0);
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_eq("reset_rw0", rw0_dataOut, 32'h0);
    check_eq("reset_rw1", rw1_dataOut, 32'h0);

    // Load a value onto rw0_dataOut, then reset asynchronously mid-cycle.
    p0(1'b1, 1'b1, 10'd7, 4'hF, 32'hDEADBEEF); tick();
    p0(1'b1, 1'b0, 10'd7, 4'h0, 32'h0);        tick();
    check_eq("pre_reset_read", rw0_dataOut, 32'hDEADBEEF);
    #2 reset_n = 1'b0;
    #1 check_eq("async_reset_rw0", rw0_dataOut, 32'h0);
    idle();
    @(negedge clock);
    // Accesses during reset must be ignored.
    p0(1'b1, 1'b1, 10'd7, 4'hF, 32'h0BADF00D);
    tick();
    idle();
    reset_n = 1'b1;
    tick(); tick();
    check_eq("post_reset_rw0", rw0_dataOut, 32'h0);
    check_eq("post_reset_rw1", rw1_dataOut, 32'h0);
    p0(1'b1, 1'b0, 10'd7, 4'h0, 32'h0); tick();
    check_eq("write_in_reset_ignored", rw0_dataOut, 32'hDEADBEEF);

    // Basic write/read; write cycle keeps dataOut.
    p0(1'b1, 1'b1, 10'd5, 4'hF, 32'h12345678); tick();
    check_eq("write_no_change", rw0_dataOut, 32'hDEADBEEF);
    p0(1'b1, 1'b0, 10'd5, 4'h0, 32'h0); tick();
    check_eq("basic_read", rw0_dataOut, 32'h12345678);
    check_eq("tied_rw1_zero", rw1_dataOut, 32'h0);

    // Masked write, mask ignored on read.
    p0(1'b1, 1'b1, 10'd5, 4'b0101, 32'hAABBCCDD); tick();
    check_eq("masked_write_no_change", rw0_dataOut, 32'h12345678);
    p0(1'b1, 1'b0, 10'd5, 4'b0000, 32'h0); tick();
    check_eq("masked_read", rw0_dataOut, 32'h12BB56DD);

    // Idle holds.
    idle(); tick(); tick(); tick();
    check_eq("idle_hold", rw0_dataOut, 32'h12BB56DD);

    // Cross-port read/write collision.
    p0(1'b1, 1'b1, 10'd9, 4'hF, 32'h22222222); tick();
    p0(1'b1, 1'b1, 10'd9, 4'hF, 32'h11111111);
    p1(1'b1, 1'b0, 10'd9, 4'h0, 32'h0);        tick();
    check_eq("cross_old_data", rw1_dataOut, 32'h22222222);
    p0(1'b1, 1'b0, 10'd9, 4'h0, 32'h0);        tick();
    check_eq("cross_new_data_rw1", rw1_dataOut, 32'h11111111);
    check_eq("same_port_raw_rw0", rw0_dataOut, 32'h11111111);

    // Dual-write collision: lane3 old, lane2 rw1, lane1 both->rw1, lane0 rw0.
    idle();
    p0(1'b1, 1'b1, 10'd3, 4'hF, 32'h77777777); tick();
    p0(1'b1, 1'b1, 10'd3, 4'b0011, 32'hAAAAAAAA);
    p1(1'b1, 1'b1, 10'd3, 4'b0110, 32'h55555555); tick();
    p0(1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
    p1(1'b1, 1'b0, 10'd3, 4'h0, 32'h0);          tick();
    check_eq("dual_write_rw0", rw0_dataOut, 32'h775555AA);
    check_eq("dual_read_rw1", rw1_dataOut, 32'h775555AA);

    // Boundary addresses.
    idle();
    p1(1'b1, 1'b1, 10'd999, 4'hF, 32'hCAFEF00D);  tick();
    p1(1'b1, 1'b0, 10'd999, 4'h0, 32'h0);         tick();
    check_eq("last_word_read", rw1_dataOut, 32'hCAFEF00D);
    p0(1'b1, 1'b1, 10'd1010, 4'hF, 32'hBADBAD00);
    p1(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);           tick();
    p0(1'b1, 1'b0, 10'd1010, 4'h0, 32'h0);
    p1(1'b1, 1'b0, 10'd1010, 4'h0, 32'h0);        tick();
    check_eq("oob_read_rw0", rw0_dataOut, 32'h0);
    check_eq("oob_read_rw1", rw1_dataOut, 32'h0);
    p0(1'b1, 1'b0, 10'd999, 4'h0, 32'h0);
    p1(1'b1, 1'b0, 10'd5, 4'h0, 32'h0);           tick();
    check_eq("last_word_intact", rw0_dataOut, 32'hCAFEF00D);
    check_eq("addr5_intact", rw1_dataOut, 32'h12BB56DD);

    idle(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_fpga_2rw.md
Name: sram_fpga_2rw

Overview:
- Behavioural true-dual-port synchronous SRAM with two identical read/write ports, rw0 and rw1, and a per-lane write mask.
- Serves as the FPGA/simulation fallback behind the per-macro SRAM wrappers whenever no ASIC macro is selected.
- Single-port users tie rw1 inactive and drive rw0_mask with all ones.
- Must infer block RAM on FPGA: no reset of the array contents.

Parameters:
- DEPTH, 1024, number of words; legal range 2..2^ADDR_WIDTH.
- ADDR_WIDTH, 10, address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- DATA_WIDTH, 32, word width in bits.
- MASK_UNIT, 8, bits per mask lane; DATA_WIDTH must be a multiple of MASK_UNIT; MASK_WIDTH = DATA_WIDTH/MASK_UNIT (derived localparam).

Ports:
- clock  in  1  single clock for both ports; all activity on the rising edge.
- reset_n  in  1  asynchronous, active-low reset (clears output registers only).
- rw0_enable  in  1  port 0 access request this cycle.
- rw0_write  in  1  1 = write, 0 = read; ignored when rw0_enable=0.
- rw0_addr  in  ADDR_WIDTH  port 0 word address.
- rw0_mask  in  MASK_WIDTH  port 0 lane write enables; bit i covers data bits [i*MASK_UNIT +: MASK_UNIT].
- rw0_dataIn  in  DATA_WIDTH  port 0 write data.
- rw0_dataOut  out  DATA_WIDTH  port 0 registered read data.
- rw1_enable, rw1_write, rw1_addr, rw1_mask, rw1_dataIn, rw1_dataOut: same widths and meanings as the rw0 ports, for port 1.

Behaviour:
- Reset: reset_n low asynchronously forces rw0_dataOut = rw1_dataOut = 0. Array contents are neither cleared nor modified. Accesses presented while reset_n is low are ignored.
- Read (enable=1, write=0) at edge N: dataOut presents mem[addr] after edge N, a 1-cycle latency. The mask is ignored on reads.
- Write (enable=1, write=1) at edge N: for each lane i with mask[i]=1, the lane is updated with the dataIn lane. Lanes with mask[i]=0 keep their old value.
- dataOut on write cycles: no-change mode; dataOut keeps its previous value.
- Idle (enable=0): dataOut holds its last value indefinitely; nothing is written.
- Out-of-range address (addr >= DEPTH): writes are discarded; reads return 0.
- Same-port read after write: a read at edge N+1 of the address written at edge N returns the new data.
- Cross-port read/write collision (same address, same edge): the reading port returns the OLD word (read-before-write). The write still takes effect.
- Dual-write collision (same address, same edge):
  - lanes masked by only one port take that port's data;
  - lanes masked by both ports take rw1's data (port 1 priority);
  - the result must be deterministic.
- Both ports reading the same address: both return the same data.
- Uninitialised words read X in simulation. Optional `SRAM_INIT_ZERO define initialises the array to 0.
- Elaboration-time checks, failing with $fatal:
  - DATA_WIDTH % MASK_UNIT != 0;
  - 2^ADDR_WIDTH < DEPTH.
- Tied-off port (enable=0, other inputs 0): no effect on the other port; its dataOut stays 0 after reset.

Test Plan:
- Reset/idle: assert reset_n=0 mid-operation with rw0_dataOut=0xDEADBEEF -> rw0_dataOut=0 immediately (asynchronous). Deassert with enable=0 -> both outputs stay 0.
- Basic write/read: rw0 writes 0x12345678 to addr 5 with mask=4'b1111, then reads addr 5 -> rw0_dataOut=0x12345678 one cycle after the read edge. rw0_dataOut unchanged during the write cycle.
- Masked write: addr 5 holds 0x12345678; write 0xAABBCCDD with mask=4'b0101 -> subsequent read returns 0x12BB56DD.
- Cross-port read/write: rw0 writes 0x11111111 to addr 9 (old value 0x22222222) while rw1 reads addr 9 on the same edge -> rw1_dataOut=0x22222222. rw1 reading addr 9 on the next edge -> 0x11111111.
- Dual write collision: same edge, rw0 writes 0xAAAAAAAA with mask 4'b0011 and rw1 writes 0x55555555 with mask 4'b0110 to addr 3 -> read returns 0x??5555AA, where the top lane keeps its old value.
- Boundary: with DEPTH=1000 and ADDR_WIDTH=10, write addr 999 then read it -> data returned. Write addr 1010 -> discarded; read addr 1010 -> 0; addr 999 unaffected.
